// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_PASS  = 3'd1,
    ST_ENTRY_OPEN = 3'd2,
    ST_EXIT_OPEN  = 3'd3,
    ST_LOCKOUT    = 3'd4
  } gate_state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

  localparam logic [1:0] DEF_PASS_1      = 2'b01;
  localparam logic [1:0] DEF_PASS_2      = 2'b10;
  localparam int         DEF_CAPACITY    = 8;
  localparam int         DEF_CNT_W       = 4;
  localparam int         DEF_TIMEOUT     = 64;
  localparam int         DEF_RETRY_MAX   = 3;
  localparam int         DEF_LOCK_CYCLES = 256;

  // Bits needed to count 0..max(a,b)-1; never less than one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Shared interval timer: counts up from zero, restarts on clear, and flags
// the cycle in which the count sits at the programmed terminal value.
module gate_timer #(
  parameter int W = 8
) (
  input  logic         clock_in,
  input  logic         rst_in,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  // Up-count, restarting whenever the owner changes interval.
  always_ff @(posedge clock_in) begin
    if (rst_in || clear) count <= '0;
    else                 count <= count + 1'b1;
  end

  assign done = (count == limit);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier controller for one entry lane and one exit lane sharing a gate.
// Arbitrates requests, sequences password entry and tracks lot occupancy.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | gate down, looking for an eligible request
// WAIT_PASS  | entry granted, waiting for the password (red lamp)
// ENTRY_OPEN | gate up for an incoming car
// EXIT_OPEN  | gate up for an outgoing car
// LOCKOUT    | too many wrong passwords, all requests ignored
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int         CAPACITY    = DEF_CAPACITY,
  parameter int         CNT_W       = DEF_CNT_W,
  parameter logic [1:0] PASS_1      = DEF_PASS_1,
  parameter logic [1:0] PASS_2      = DEF_PASS_2,
  parameter int         TIMEOUT     = DEF_TIMEOUT,
  parameter int         RETRY_MAX   = DEF_RETRY_MAX,
  parameter int         LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic             entry_req,
  input  logic             entry_done,
  input  logic             exit_req,
  input  logic             exit_done,
  input  logic [1:0]       pass_1,
  input  logic [1:0]       pass_2,
  input  logic             pass_valid,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             G_LED,
  output logic             R_LED,
  output logic             alarm,
  output logic             lot_full,
  output logic [CNT_W-1:0] occupancy
);

  localparam int TMR_W = timer_width(TIMEOUT, LOCK_CYCLES);
  localparam int RTY_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TO_LIM   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LIM = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_V    = RTY_W'(RETRY_MAX);

  gate_state_t      state_q, state_d;
  lane_t            last_q, last_d;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic             entry_ok, exit_ok, pass_ok;
  logic             restart;
  logic             tmr_clear, tmr_done;
  logic [TMR_W-1:0] tmr_limit;

  assign entry_ok  = entry_req && (occ_q != CAP_V);
  assign exit_ok   = exit_req && (occ_q != '0);
  assign pass_ok   = (pass_1 == PASS_1) && (pass_2 == PASS_2);
  assign retry_inc = retry_q + RTY_W'(1);

  // The timer is held at zero in IDLE and restarts on any state change
  // or on a wrong password, so every waiting state gets a full interval.
  assign tmr_clear = (state_q == ST_IDLE) || (state_d != state_q) || restart;
  assign tmr_limit = (state_q == ST_LOCKOUT) ? LOCK_LIM : TO_LIM;

  gate_timer #(
    .W(TMR_W)
  ) u_timer (
    .clock_in (clock_in),
    .rst_in   (rst_in),
    .clear    (tmr_clear),
    .limit    (tmr_limit),
    .done     (tmr_done)
  );

  // State, arbitration history, retry count and occupancy registers.
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      last_q  <= LANE_EXIT;
      retry_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      retry_q <= retry_d;
      occ_q   <= occ_d;
    end
  end

  // Next-state logic; completion events take priority over the timeout.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    retry_d = retry_q;
    occ_d   = occ_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (entry_ok && (!exit_ok || last_q == LANE_EXIT)) begin
          state_d = ST_WAIT_PASS;
          last_d  = LANE_ENTRY;
        end else if (exit_ok) begin
          state_d = ST_EXIT_OPEN;
          last_d  = LANE_EXIT;
        end
      end
      ST_WAIT_PASS: begin
        if (pass_valid && pass_ok) begin
          state_d = ST_ENTRY_OPEN;
          retry_d = '0;
        end else begin
          if (pass_valid) begin
            retry_d = retry_inc;
            restart = 1'b1;
          end
          // A mismatch is counted before an abandon on the same edge; if it
          // was the last allowed attempt, lockout wins.
          if (pass_valid && (retry_inc == RTY_V)) begin
            state_d = ST_LOCKOUT;
          end else if (!entry_req || tmr_done) begin
            state_d = ST_IDLE;
            retry_d = '0;
          end
        end
      end
      ST_ENTRY_OPEN: begin
        if (entry_done) begin
          if (occ_q != CAP_V) occ_d = occ_q + CNT_W'(1);
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXIT_OPEN: begin
        if (exit_done) begin
          if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    gate_open   = 1'b0;
    grant_entry = 1'b0;
    grant_exit  = 1'b0;
    G_LED       = 1'b0;
    R_LED       = 1'b0;
    alarm       = 1'b0;
    case (state_q)
      ST_WAIT_PASS: begin
        R_LED       = 1'b1;
        grant_entry = 1'b1;
      end
      ST_ENTRY_OPEN: begin
        gate_open   = 1'b1;
        G_LED       = 1'b1;
        grant_entry = 1'b1;
      end
      ST_EXIT_OPEN: begin
        gate_open  = 1'b1;
        G_LED      = 1'b1;
        grant_exit = 1'b1;
      end
      ST_LOCKOUT: begin
        alarm = 1'b1;
        R_LED = 1'b1;
      end
      default: ;
    endcase
  end

  assign occupancy = occ_q;
  assign lot_full  = (occ_q == CAP_V);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with hand-computed expectations.
module tb_parking_gate_ctrl;

  logic       clock_in;
  logic       rst_in;
  logic       entry_req, entry_done, exit_req, exit_done;
  logic [1:0] pass_1, pass_2;
  logic       pass_valid;
  logic       gate_open, grant_entry, grant_exit, G_LED, R_LED, alarm, lot_full;
  logic [3:0] occupancy;
  logic [5:0] outs;

  int vectors    = 0;
  int miscompares = 0;

  // {gate_open, G_LED, R_LED, grant_entry, grant_exit, alarm}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_WAIT  = 6'b001100;
  localparam logic [5:0] O_ENTRY = 6'b110100;
  localparam logic [5:0] O_EXIT  = 6'b110010;
  localparam logic [5:0] O_LOCK  = 6'b001001;

  assign outs = {gate_open, G_LED, R_LED, grant_entry, grant_exit, alarm};

  parking_gate_ctrl dut (
    .clock_in    (clock_in),
    .rst_in      (rst_in),
    .entry_req   (entry_req),
    .entry_done  (entry_done),
    .exit_req    (exit_req),
    .exit_done   (exit_done),
    .pass_1      (pass_1),
    .pass_2      (pass_2),
    .pass_valid  (pass_valid),
    .gate_open   (gate_open),
    .grant_entry (grant_entry),
    .grant_exit  (grant_exit),
    .G_LED       (G_LED),
    .R_LED       (R_LED),
    .alarm       (alarm),
    .lot_full    (lot_full),
    .occupancy   (occupancy)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic car_in();
    entry_req = 1'b1;
    tick();
    pass_1 = 2'b01; pass_2 = 2'b10; pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
    entry_req  = 1'b0;
    entry_done = 1'b1;
    tick();
    entry_done = 1'b0;
  endtask

  task automatic car_out();
    exit_req = 1'b1;
    tick();
    exit_req  = 1'b0;
    exit_done = 1'b1;
    tick();
    exit_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({outs, lot_full, occupancy} !== {O_IDLE, 1'b0, 4'd0}) begin
      $display("FAIL reset: outs=%b full=%b occ=%0d, want outs=%b full=0 occ=0", outs, lot_full, occupancy, O_IDLE);
      miscompares++;
    end
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    vectors++;
    if (outs !== O_IDLE) begin
      $display("FAIL exit_when_empty: outs=%b want %b", outs, O_IDLE);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_basic_entry();
    entry_req = 1'b1;
    tick();
    vectors++;
    if (outs !== O_WAIT) begin
      $display("FAIL entry_grant: outs=%b want %b", outs, O_WAIT);
      miscompares++;
    end
    pass_1 = 2'b01; pass_2 = 2'b10; pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
    vectors++;
    if (outs !== O_ENTRY) begin
      $display("FAIL entry_open: outs=%b want %b", outs, O_ENTRY);
      miscompares++;
    end
    entry_req  = 1'b0;
    entry_done = 1'b1;
    tick();
    entry_done = 1'b0;
    vectors++;
    if ({outs, occupancy} !== {O_IDLE, 4'd1}) begin
      $display("FAIL entry_done: outs=%b occ=%0d want outs=%b occ=1", outs, occupancy, O_IDLE);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_arbitration();
    do_reset();
    car_in(); car_in(); car_in();
    car_out();
    tick();
    vectors++;
    if (occupancy !== 4'd2) begin
      $display("FAIL arb_setup_occ: occ=%0d want 2", occupancy);
      miscompares++;
    end
    entry_req = 1'b1;
    exit_req  = 1'b1;
    tick();
    vectors++;
    if (outs !== O_WAIT) begin
      $display("FAIL arb_entry_first: outs=%b want %b", outs, O_WAIT);
      miscompares++;
    end
    pass_1 = 2'b01; pass_2 = 2'b10; pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
    entry_done = 1'b1;
    tick();
    entry_done = 1'b0;
    vectors++;
    if ({outs, occupancy} !== {O_IDLE, 4'd3}) begin
      $display("FAIL arb_idle_gap: outs=%b occ=%0d want outs=%b occ=3", outs, occupancy, O_IDLE);
      miscompares++;
    end
    tick();
    vectors++;
    if (outs !== O_EXIT) begin
      $display("FAIL arb_exit_second: outs=%b want %b", outs, O_EXIT);
      miscompares++;
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_done = 1'b1;
    tick();
    exit_done = 1'b0;
    vectors++;
    if ({outs, occupancy} !== {O_IDLE, 4'd2}) begin
      $display("FAIL arb_exit_done: outs=%b occ=%0d want outs=%b occ=2", outs, occupancy, O_IDLE);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_lockout();
    int  cnt;
    logic leak;
    do_reset();
    entry_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      pass_1 = 2'b11; pass_2 = 2'b11; pass_valid = 1'b1;
      tick();
      pass_valid = 1'b0;
      vectors++;
      if (outs !== ((i < 2) ? O_WAIT : O_LOCK)) begin
        $display("FAIL wrong_pass_%0d: outs=%b want %b", i, outs, (i < 2) ? O_WAIT : O_LOCK);
        miscompares++;
      end
    end
    cnt  = 0;
    leak = 1'b0;
    while (alarm === 1'b1 && cnt < 400) begin
      if (grant_entry !== 1'b0 || gate_open !== 1'b0) leak = 1'b1;
      cnt++;
      tick();
    end
    vectors++;
    if (cnt != 256) begin
      $display("FAIL lockout_len: alarm cycles=%0d want 256", cnt);
      miscompares++;
    end
    vectors++;
    if (leak !== 1'b0) begin
      $display("FAIL lockout_ignore: grant seen=%b want 0", leak);
      miscompares++;
    end
    vectors++;
    if (outs !== O_IDLE) begin
      $display("FAIL lockout_exit: outs=%b want %b", outs, O_IDLE);
      miscompares++;
    end
    tick();
    vectors++;
    if (outs !== O_WAIT) begin
      $display("FAIL post_lock_grant: outs=%b want %b", outs, O_WAIT);
      miscompares++;
    end
    entry_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) car_in();
    tick();
    vectors++;
    if ({lot_full, occupancy} !== {1'b1, 4'd8}) begin
      $display("FAIL fill: full=%b occ=%0d want full=1 occ=8", lot_full, occupancy);
      miscompares++;
    end
    entry_req = 1'b1;
    tick(); tick(); tick();
    entry_req = 1'b0;
    vectors++;
    if (outs !== O_IDLE) begin
      $display("FAIL full_no_grant: outs=%b want %b", outs, O_IDLE);
      miscompares++;
    end
    exit_req = 1'b1;
    tick();
    vectors++;
    if (outs !== O_EXIT) begin
      $display("FAIL full_exit_grant: outs=%b want %b", outs, O_EXIT);
      miscompares++;
    end
    exit_req  = 1'b0;
    exit_done = 1'b1;
    tick();
    exit_done = 1'b0;
    vectors++;
    if ({outs, lot_full, occupancy} !== {O_IDLE, 1'b0, 4'd7}) begin
      $display("FAIL full_exit_done: outs=%b full=%b occ=%0d want idle full=0 occ=7", outs, lot_full, occupancy);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    entry_req = 1'b1;
    tick();
    cnt = 0;
    while (R_LED === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    entry_req = 1'b0;
    vectors++;
    if (cnt != 64 || outs !== O_IDLE) begin
      $display("FAIL pass_timeout: R_LED cycles=%0d outs=%b want 64 and %b", cnt, outs, O_IDLE);
      miscompares++;
    end
    tick();
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    cnt = 0;
    while (gate_open === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    vectors++;
    if (cnt != 64 || occupancy !== 4'd7) begin
      $display("FAIL exit_timeout: open cycles=%0d occ=%0d want 64 and 7", cnt, occupancy);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_boundaries();
    entry_req = 1'b1;
    tick();
    repeat (63) tick();
    vectors++;
    if (outs !== O_WAIT) begin
      $display("FAIL wait_last_cycle: outs=%b want %b", outs, O_WAIT);
      miscompares++;
    end
    pass_1 = 2'b01; pass_2 = 2'b10; pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
    entry_req  = 1'b0;
    vectors++;
    if (outs !== O_ENTRY) begin
      $display("FAIL pass_on_timeout: outs=%b want %b", outs, O_ENTRY);
      miscompares++;
    end
    repeat (63) tick();
    entry_done = 1'b1;
    tick();
    entry_done = 1'b0;
    vectors++;
    if ({outs, lot_full, occupancy} !== {O_IDLE, 1'b1, 4'd8}) begin
      $display("FAIL done_on_timeout: outs=%b full=%b occ=%0d want idle full=1 occ=8", outs, lot_full, occupancy);
      miscompares++;
    end
    exit_done = 1'b1;
    tick();
    exit_done = 1'b0;
    vectors++;
    if (occupancy !== 4'd8) begin
      $display("FAIL stray_done_idle: occ=%0d want 8", occupancy);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) car_in();
    entry_req = 1'b1;
    tick();
    pass_1 = 2'b01; pass_2 = 2'b10; pass_valid = 1'b1;
    tick();
    pass_valid = 1'b0;
    entry_req  = 1'b0;
    exit_done  = 1'b1;
    tick();
    exit_done = 1'b0;
    vectors++;
    if ({outs, occupancy} !== {O_ENTRY, 4'd5}) begin
      $display("FAIL wrong_lane_done: outs=%b occ=%0d want %b occ=5", outs, occupancy, O_ENTRY);
      miscompares++;
    end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    vectors++;
    if ({outs, lot_full, occupancy} !== {O_IDLE, 1'b0, 4'd0}) begin
      $display("FAIL reset_mid: outs=%b full=%b occ=%0d want all zero", outs, lot_full, occupancy);
      miscompares++;
    end
  endtask

  initial begin
    rst_in     = 1'b1;
    entry_req  = 1'b0;
    entry_done = 1'b0;
    exit_req   = 1'b0;
    exit_done  = 1'b0;
    pass_1     = 2'b00;
    pass_2     = 2'b00;
    pass_valid = 1'b0;
    tick();
    test_reset();
    test_basic_entry();
    test_arbitration();
    test_lockout();
    test_full();
    test_timeout();
    test_boundaries();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Controller for a single shared barrier gate serving one entry lane and one exit lane. It arbitrates between entry and exit requests and sequences password entry for incoming cars. It also tracks lot occupancy against a fixed capacity and drives the gate, the LEDs and the occupancy outputs. It sits above the existing `parking_system` password/LED datapath and owns the barrier and the car count.

## Interface
- `CAPACITY`, 8: number of slots; must be 1..2**CNT_W-1.
- `CNT_W`, 4: occupancy counter width.
- `PASS_1`, 2'b01: expected first password digit.
- `PASS_2`, 2'b10: expected second password digit.
- `TIMEOUT`, 64: cycles allowed in any waiting state before abandoning the request.
- `RETRY_MAX`, 3: wrong passwords allowed before lockout.
- `LOCK_CYCLES`, 256: lockout duration in cycles.

Ports:
- `clock_in`  in  1  system clock; single clock domain.
- `rst_in`  in  1  reset; synchronous and active-high.
- `entry_req`  in  1  car present at entry front sensor (level).
- `entry_done`  in  1  car cleared entry back sensor (1-cycle pulse).
- `exit_req`  in  1  car present at exit front sensor (level).
- `exit_done`  in  1  car cleared exit back sensor (1-cycle pulse).
- `pass_1`, `pass_2`  in  2 each  password digits; sampled only when `pass_valid` is high.
- `pass_valid`  in  1  password-submit strobe.
- `gate_open`  out  1  barrier raised.
- `grant_entry`, `grant_exit`  out  1 each  which lane currently owns the gate; one-hot or zero.
- `G_LED`  out  1  green lamp.
- `R_LED`  out  1  red lamp.
- `alarm`  out  1  lockout indicator.
- `lot_full`  out  1  asserted when occupancy equals `CAPACITY`.
- `occupancy`  out  CNT_W  cars currently inside.

## Operation
- States: IDLE, WAIT_PASS, ENTRY_OPEN, EXIT_OPEN, LOCKOUT.
- All outputs are decoded from registered state and counters, so there is no combinational input-to-output path.
- IDLE:
  - Entry is eligible when `entry_req` is high and `lot_full` is low.
  - Exit is eligible when `exit_req` is high and `occupancy` is nonzero.
  - If both are eligible, grant the lane not granted last. `last_grant` resets to exit, so entry wins the first tie.
  - Entry goes to WAIT_PASS; exit goes to EXIT_OPEN.
  - Outputs: all low.
- WAIT_PASS:
  - Outputs: `R_LED`=1, `grant_entry`=1.
  - On `pass_valid` with both digits matching: go to ENTRY_OPEN and clear the retry counter.
  - On `pass_valid` with a mismatch: increment the retry counter and restart the timer.
  - When the retry counter reaches RETRY_MAX: go to LOCKOUT.
  - If `entry_req` drops or the timer reaches TIMEOUT: go to IDLE and clear the retry counter.
- ENTRY_OPEN:
  - Outputs: `gate_open`=1, `G_LED`=1, `grant_entry`=1.
  - On `entry_done`: increment `occupancy` and go to IDLE.
  - On timer reaching TIMEOUT: go to IDLE with no count change.
- EXIT_OPEN:
  - Outputs: `gate_open`=1, `G_LED`=1, `grant_exit`=1.
  - On `exit_done`: decrement `occupancy` and go to IDLE.
  - On timer reaching TIMEOUT: go to IDLE with no count change.
- LOCKOUT:
  - Outputs: `alarm`=1, `R_LED`=1.
  - All requests are ignored.
  - After LOCK_CYCLES cycles: go to IDLE and clear the retry counter.
- The timer clears on every state change.
- `occupancy` saturates at 0 and CAPACITY; it never wraps.
- A `*_done` pulse counts only in the matching OPEN state. `exit_done` during ENTRY_OPEN and stray pulses in IDLE are ignored.
- `lot_full` is `occupancy == CAPACITY`. It updates in the same cycle as the count.

## Timing
- Reset values: state IDLE, all outputs 0, `occupancy`=0, retry counter 0, `last_grant`=exit.
- Reset mid-operation also clears `occupancy`; the count is not preserved.
- Request sampled at edge N produces the grant and state outputs from cycle N+1.
- `pass_valid` at edge N produces `gate_open` from N+1.
- `*_done` at edge N:
  - `gate_open` is low from N+1.
  - `occupancy` is updated from N+1.
  - A new grant is possible no earlier than edge N+1, with outputs from N+2. There is a minimum of one idle cycle between grants.
- Timeout: the state exits on the edge where the timer equals TIMEOUT-1, so a state lasts at most TIMEOUT cycles.
- Simultaneous events:
  - `pass_valid` with the timeout edge: the password takes priority.
  - `entry_done` with the timeout edge: the count takes priority.
  - Mismatch and timeout on the same edge: the mismatch is counted, then the request is abandoned.

## Structure
- Shared package `parking_pkg` holds:
  - the state enum `gate_state_t`;
  - the default password constants;
  - the lane enum `lane_t` used for `last_grant`.
- One sub-module, `gate_timer`: a resettable up-counter with a `clear` input and a terminal flag, sized for max(TIMEOUT, LOCK_CYCLES). It is used for both the timeout and lockout intervals.

## Test plan
- Reset, then `entry_req`=1 and `pass_valid` with 01/10 → WAIT_PASS then ENTRY_OPEN; `gate_open`=1, `G_LED`=1; `entry_done` → `occupancy`=1, `gate_open`=0 the next cycle.
- `entry_req` and `exit_req` both high with `occupancy`=2 → entry granted first; after completion, with both still high, exit is granted.
- Three wrong passwords (11/11) → `alarm`=1 for exactly 256 cycles, `entry_req` ignored meanwhile, then return to IDLE.
- Fill to 8 cars, then `entry_req` → no grant, `lot_full`=1; `exit_req` plus `exit_done` → `occupancy`=7, `lot_full`=0.
- No `pass_valid` for 64 cycles → back to IDLE with `R_LED`=0. Exit with no `exit_done` → gate closes after 64 cycles and the count is unchanged.
- `rst_in` asserted during ENTRY_OPEN with `occupancy`=5 → next cycle all outputs 0 and `occupancy`=0.
